sap_core: RTL

SAP_CORE -- requirements
Module: sap_core

---
 rtl/sap_core.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sap_core.sv
// -----------------------------------------------------------------------------
// sap_core -- SAP-1 style accumulator CPU with on-chip program RAM.
//
// Every instruction runs through five microsteps, T0..T4:
//   T0  MAR <= PC
//   T1  IR  <= RAM[MAR], PC <= PC + 1
//   T2..T4  opcode-specific execute
// The only exceptions are an OUT that is waiting for its handshake and a
// halted core.
//
// Instruction word: opcode = [DATA_W-1 -: 4], operand = [ADDR_W-1:0].
//   0 NOP   1 LDA   2 ADD   3 SUB   4 STA   5 LDI   6 JMP
//   7 JC    8 JZ    E OUT   F HLT   (9..D behave as NOP)
//
// Optional feature macro: SAP_CORE_FLAGS_EN
//   defined   : carry/zero flags, written by ADD/SUB; JC/JZ test them.
//   undefined : no flag registers; JC/JZ behave as NOP.
//
// Ports
//   clk        single clock
//   rst        asynchronous reset, active low
//   prog_mode  1 = program-load mode (core idle, PC/step parked at 0/T0)
//   prog_we    RAM write strobe, honoured only in program mode
//   prog_addr  RAM write address
//   prog_data  RAM write data
//   out_data   value produced by OUT; holds its last value
//   out_valid  out_data valid (source side of a valid/ready handshake)
//   out_ready  sink accepts out_data
//   halted     HLT has executed
//   pc_dbg     current program counter
// -----------------------------------------------------------------------------
module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [2:0]        step_q, step_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic [3:0]        opcode;
    logic [3:0]        fetch_op;
    logic [ADDR_W-1:0] operand;
    logic              is_sub;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;

    assign opcode   = ir_q[DATA_W-1 -: 4];
    assign operand  = ir_q[ADDR_W-1:0];
    // Opcode of the word arriving from RAM during T1, before it reaches IR.
    assign fetch_op = rdata_q[DATA_W-1 -: 4];

    // SUB is A + ~B + 1: invert B and feed the +1 in as the carry-in.
    assign is_sub = (opcode == OP_SUB);
    assign alu_b  = is_sub ? ~b_q : b_q;

`ifdef SAP_CORE_FLAGS_EN
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic [DATA_W:0] alu_sum;

    assign alu_sum = {1'b0, a_q} + {1'b0, alu_b} + (DATA_W+1)'(is_sub);
    assign alu_res = alu_sum[DATA_W-1:0];
`else
    assign alu_res = a_q + alu_b + DATA_W'(is_sub);
`endif

    always_comb begin
        // NOTE: every output of this block is given its hold value first, so
        // no path through the case statements can leave one unassigned and
        // infer a latch.
        pc_d        = pc_q;
        mar_d       = mar_q;
        step_d      = step_q;
        a_d         = a_q;
        b_d         = b_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        ram_we      = 1'b0;
        ram_waddr   = mar_q;
        ram_wdata   = a_q;
`ifdef SAP_CORE_FLAGS_EN
        carry_d     = carry_q;
        zero_d      = zero_q;
`endif

        if (prog_mode) begin
            // Park the sequencer. Any instruction in flight is dropped here,
            // including a pending STA write or an OUT handshake.
            pc_d        = '0;
            step_d      = T0;
            halted_d    = 1'b0;
            out_valid_d = 1'b0;
            ram_we      = prog_we;
            ram_waddr   = prog_addr;
            ram_wdata   = prog_data;
        end else if (!halted_q) begin
            case (step_q)
                T0: begin
                    mar_d  = pc_q;
                    step_d = T1;
                end
                T1: begin
                    ir_d   = rdata_q;
                    pc_d   = pc_q + ADDR_W'(1);
                    step_d = T2;
                    // Raise OUT's valid as it enters T2. A is already final
                    // here, so out_data is stable for the whole handshake.
                    if (fetch_op == OP_OUT) begin
                        out_valid_d = 1'b1;
                        out_data_d  = a_q;
                    end
                end
                T2: begin
                    step_d = T3;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
                        OP_LDI: a_d  = DATA_W'(operand);
                        OP_JMP: pc_d = operand;
                        OP_JC: begin
`ifdef SAP_CORE_FLAGS_EN
                            if (carry_q) pc_d = operand;
`endif
                        end
                        OP_JZ: begin
`ifdef SAP_CORE_FLAGS_EN
                            if (zero_q) pc_d = operand;
`endif
                        end
                        OP_OUT: begin
                            if (out_ready) out_valid_d = 1'b0;
                            else           step_d      = T2;
                        end
                        OP_HLT: begin
                            halted_d = 1'b1;
                            step_d   = T2;
                        end
                        OP_NOP: ;
                        default: ;
                    endcase
                end
                T3: begin
                    step_d = T4;
                    case (opcode)
                        OP_LDA:         a_d    = rdata_q;
                        OP_ADD, OP_SUB: b_d    = rdata_q;
                        OP_STA:         ram_we = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    step_d = T0;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        a_d = alu_res;
`ifdef SAP_CORE_FLAGS_EN
                        carry_d = alu_sum[DATA_W];
                        zero_d  = (alu_res == '0);
`endif
                    end
                end
                default: step_d = T0;
            endcase
        end
    end

    // NOTE: the RAM array has no reset branch. Its contents must survive rst,
    // and leaving it out also lets the array map onto a plain synchronous RAM.
    // The read address is the MAR value being loaded this edge, so the data
    // for a T0 or T2 address load is ready in the following step.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rdata_q <= mem[mar_d];
    end

    // NOTE: all state updates use non-blocking assignments, so every flop
    // samples the values from before this edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            mar_q       <= '0;
            step_q      <= T0;
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

`ifdef SAP_CORE_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc_dbg    = pc_q;

endmodule
